// File: rtl/biriscv_issue_hazard_if.sv
// ---------------------------------------------------------------------------
// biriscv_issue_hazard_if
// Issue-side handshake between the decoder and the hazard/forwarding unit.
//   decoded instruction : issue_valid_i, issue_ra_i, issue_rb_i,
//                         issue_rd_valid_i, issue_rd_i,
//                         issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i
//   issue decision      : issue_accept_o, issue_stall_o
//   forwarded operands  : operand_ra_o, operand_rb_o
// master = decoder side, slave = hazard unit side.
// ---------------------------------------------------------------------------
interface biriscv_issue_hazard_if;
    logic        issue_valid_i;
    logic [4:0]  issue_ra_i;
    logic [4:0]  issue_rb_i;
    logic        issue_rd_valid_i;
    logic [4:0]  issue_rd_i;
    logic        issue_lsu_i;
    logic        issue_mul_i;
    logic        issue_div_i;
    logic        issue_csr_i;
    logic        issue_accept_o;
    logic        issue_stall_o;
    logic [31:0] operand_ra_o;
    logic [31:0] operand_rb_o;

    modport master (
        output issue_valid_i, issue_ra_i, issue_rb_i, issue_rd_valid_i, issue_rd_i,
               issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i,
        input  issue_accept_o, issue_stall_o, operand_ra_o, operand_rb_o
    );

    modport slave (
        input  issue_valid_i, issue_ra_i, issue_rb_i, issue_rd_valid_i, issue_rd_i,
               issue_lsu_i, issue_mul_i, issue_div_i, issue_csr_i,
        output issue_accept_o, issue_stall_o, operand_ra_o, operand_rb_o
    );
endinterface

// File: rtl/biriscv_issue_hazard.sv
// ---------------------------------------------------------------------------
// biriscv_issue_hazard
// Issue-side hazard detection and operand forwarding.
//   clk_i / rst_ni      : clock, synchronous active-low reset
//   issue (slave)       : decoded instruction in, accept/stall/operands out
//   rf_r*_value_i       : register-file read data
//   *_e1_i / *_e2_i     : destination, kind and result of the E1/E2 stages
//   rd_wb_i/result_wb_i : writeback destination and result
//   pipe_stall_i        : downstream stall
//   squash_i            : flush of E1/E2 (exception/interrupt)
//   div_complete_i      : divider result ready
//   div_busy_o          : divider occupied
//   hazard_stall_cnt_o  : saturating count of cycles lost to RAW hazards
// HAZARD_CNT_INIT sets the value the stall counter takes on reset.
// ---------------------------------------------------------------------------
module biriscv_issue_hazard #(
    parameter bit          SUPPORT_LOAD_BYPASS = 1'b1,
    parameter bit          SUPPORT_MUL_BYPASS  = 1'b1,
    parameter bit          SUPPORT_DIVIDE      = 1'b1,
    parameter logic [31:0] HAZARD_CNT_INIT     = 32'h0000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    biriscv_issue_hazard_if.slave       issue,
    input  logic [31:0]                 rf_ra_value_i,
    input  logic [31:0]                 rf_rb_value_i,
    input  logic [4:0]                  rd_e1_i,
    input  logic                        load_e1_i,
    input  logic                        mul_e1_i,
    input  logic [31:0]                 result_e1_i,
    input  logic [4:0]                  rd_e2_i,
    input  logic                        load_e2_i,
    input  logic                        mul_e2_i,
    input  logic [31:0]                 result_e2_i,
    input  logic [4:0]                  rd_wb_i,
    input  logic [31:0]                 result_wb_i,
    input  logic                        pipe_stall_i,
    input  logic                        squash_i,
    input  logic                        div_complete_i,
    output logic                        div_busy_o,
    output logic [31:0]                 hazard_stall_cnt_o
);

    typedef enum logic [0:0] {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

    div_state_t  div_state_r;
    logic [31:0] pending_r;

    logic        e1_ok_s;
    logic        e2_ok_s;
    logic [32:0] fwd_a_s;
    logic [32:0] fwd_b_s;
    logic        hazard_s;
    logic        accept_s;
    logic        tracked_s;
    logic        cnt_inc_s;
    logic [31:0] clr_mask_s;
    logic [31:0] set_mask_s;

    // Returns {hazard, value}. The first stage whose rd matches decides the
    // outcome; an unusable match stalls even if an older stage also matches.
    function automatic logic [32:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic        pend_bit,
        input logic        e1_ok,
        input logic        e2_ok,
        input logic [4:0]  rd_e1,
        input logic [31:0] res_e1,
        input logic [4:0]  rd_e2,
        input logic [31:0] res_e2,
        input logic [4:0]  rd_wb,
        input logic [31:0] res_wb
    );
        if (src == 5'd0) begin
            fwd_sel = {1'b0, 32'h0000_0000};
        end else if (rd_e1 == src) begin
            fwd_sel = {~e1_ok, res_e1};
        end else if (rd_e2 == src) begin
            fwd_sel = {~e2_ok, res_e2};
        end else if (rd_wb == src) begin
            fwd_sel = {1'b0, res_wb};
        end else begin
            fwd_sel = {pend_bit, rf_val};
        end
    endfunction

    // Forwarding selection, hazard and accept decision.
    always_comb begin
        e1_ok_s   = ~load_e1_i & ~mul_e1_i;
        e2_ok_s   = ~(load_e2_i & ~SUPPORT_LOAD_BYPASS) & ~(mul_e2_i & ~SUPPORT_MUL_BYPASS);
        fwd_a_s   = fwd_sel(issue.issue_ra_i, rf_ra_value_i, pending_r[issue.issue_ra_i],
                            e1_ok_s, e2_ok_s, rd_e1_i, result_e1_i, rd_e2_i, result_e2_i,
                            rd_wb_i, result_wb_i);
        fwd_b_s   = fwd_sel(issue.issue_rb_i, rf_rb_value_i, pending_r[issue.issue_rb_i],
                            e1_ok_s, e2_ok_s, rd_e1_i, result_e1_i, rd_e2_i, result_e2_i,
                            rd_wb_i, result_wb_i);
        hazard_s  = fwd_a_s[32] | fwd_b_s[32];
        // A divide with no divider configured is never accepted.
        accept_s  = rst_ni & issue.issue_valid_i & ~hazard_s & ~div_busy_o & ~pipe_stall_i
                    & ~squash_i & ~(issue.issue_div_i & ~SUPPORT_DIVIDE);
        cnt_inc_s = issue.issue_valid_i & hazard_s & ~pipe_stall_i & ~squash_i;
        tracked_s = issue.issue_rd_valid_i & (issue.issue_rd_i != 5'd0)
                    & (issue.issue_lsu_i | issue.issue_mul_i | issue.issue_div_i | issue.issue_csr_i);
        clr_mask_s = (rd_wb_i != 5'd0) ? (32'h0000_0001 << rd_wb_i) : 32'h0000_0000;
        set_mask_s = (accept_s & tracked_s) ? (32'h0000_0001 << issue.issue_rd_i) : 32'h0000_0000;
    end

    assign div_busy_o           = (div_state_r == DIV_BUSY);
    assign issue.issue_accept_o = accept_s;
    assign issue.issue_stall_o  = rst_ni & (pipe_stall_i | (div_busy_o & ~div_complete_i));
    assign issue.operand_ra_o   = rst_ni ? fwd_a_s[31:0] : 32'h0000_0000;
    assign issue.operand_rb_o   = rst_ni ? fwd_b_s[31:0] : 32'h0000_0000;

    // Pending-destination scoreboard; a same-cycle set beats the WB clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_r <= 32'h0000_0000;
        end else if (squash_i) begin
            pending_r <= 32'h0000_0000;
        end else begin
            pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
        end
    end

    // Divider occupancy; a completion arriving while idle is ignored.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_state_r <= DIV_IDLE;
        end else begin
            case (div_state_r)
                DIV_IDLE: begin
                    if (accept_s & issue.issue_div_i) begin
                        div_state_r <= DIV_BUSY;
                    end else begin
                        div_state_r <= DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (div_complete_i | squash_i) begin
                        div_state_r <= DIV_IDLE;
                    end else begin
                        div_state_r <= DIV_BUSY;
                    end
                end
                default: div_state_r <= DIV_IDLE;
            endcase
        end
    end

    // Saturating RAW-hazard stall counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hazard_stall_cnt_o <= HAZARD_CNT_INIT;
        end else if (cnt_inc_s && (hazard_stall_cnt_o != 32'hFFFF_FFFF)) begin
            hazard_stall_cnt_o <= hazard_stall_cnt_o + 32'd1;
        end else begin
            hazard_stall_cnt_o <= hazard_stall_cnt_o;
        end
    end

endmodule

// File: doc/biriscv_issue_hazard.md
Name: biriscv_issue_hazard

Overview:
Issue-side hazard and operand-forwarding unit. It sits directly upstream of the E1/E2/WB pipeline control stage.
- Tracks destination registers still pending from long-latency producers (load, mul, div, CSR).
- Selects forwarded operand values from E1/E2/WB results or the register file.
- Generates the issue accept/stall decision that the pipeline control stage consumes as issue_accept/issue_stall.
- Owns the single-entry non-pipelined divider occupancy state.

Parameters:
SUPPORT_LOAD_BYPASS, 1, 1: a load in E2 may forward mem result; 0: consumer waits until WB.
SUPPORT_MUL_BYPASS, 1, 1: a mul in E2 may forward mul result; 0: consumer waits until WB.
SUPPORT_DIVIDE, 1, 0: issue_div_i is never accepted; it is held stalled (bench-visible misconfiguration).

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous reset, active low
issue_valid_i  in  1  decoded instruction present
issue_ra_i  in  5  source A index
issue_rb_i  in  5  source B index
issue_rd_valid_i  in  1  instruction writes rd
issue_rd_i  in  5  destination index
issue_lsu_i  in  1  load/store
issue_mul_i  in  1  multiply
issue_div_i  in  1  divide
issue_csr_i  in  1  CSR access
rf_ra_value_i  in  32  register-file read A
rf_rb_value_i  in  32  register-file read B
rd_e1_i  in  5  E1 destination (0 = none)
load_e1_i  in  1  E1 is load
mul_e1_i  in  1  E1 is mul
result_e1_i  in  32  E1 ALU result
rd_e2_i  in  5  E2 destination (0 = none)
load_e2_i  in  1  E2 is load
mul_e2_i  in  1  E2 is mul
result_e2_i  in  32  E2 result (bypass-muxed)
rd_wb_i  in  5  WB destination (0 = none)
result_wb_i  in  32  WB result
pipe_stall_i  in  1  downstream stall (pipeline control stall output)
squash_i  in  1  E1/E2 squash (exception/interrupt)
div_complete_i  in  1  divider result ready
issue_accept_o  out  1  instruction accepted this cycle
issue_stall_o  out  1  pipeline held (pipe_stall_i or divider wait)
operand_ra_o  out  32  forwarded operand A
operand_rb_o  out  32  forwarded operand B
div_busy_o  out  1  divider occupied
hazard_stall_cnt_o  out  32  cycles lost to RAW hazards

Behaviour:
- Reset (rst_ni low at posedge):
  - pending_q = 0.
  - Divider FSM = IDLE, so div_busy_o = 0.
  - hazard_stall_cnt_o = 0.
  - issue_accept_o = 0 while reset is held; all combinational outputs are gated by reset-held state.
- Scoreboard pending_q[31:0]; bit 0 is never set.
  - Set bit rd on an accepted issue with issue_rd_valid_i and rd != 0 and (lsu|mul|div|csr).
  - Clear bit rd_wb_i when rd_wb_i != 0.
  - Same-cycle set and clear of the same index: set wins.
  - squash_i clears all bits at the next edge.
- Forwarding, per source s (ra, rb):
  - s == 0 gives 0.
  - Otherwise priority is E1 > E2 > WB > RF, matching rd_eX == s.
  - An E1 match is usable only if ~load_e1_i & ~mul_e1_i.
  - An E2 match is usable unless (load_e2_i & ~SUPPORT_LOAD_BYPASS) or (mul_e2_i & ~SUPPORT_MUL_BYPASS).
  - A WB match is always usable.
  - The highest-priority match that is unusable gives hazard = 1; lower stages are not consulted.
  - No match with pending_q[s] set gives hazard = 1.
- Divider FSM, two states:
  - IDLE -> BUSY on an accepted div.
  - BUSY -> IDLE on div_complete_i or squash_i.
  - div_busy_o = (state == BUSY).
  - While BUSY, no issue is accepted.
  - issue_stall_o = pipe_stall_i | (BUSY & ~div_complete_i).
- issue_accept_o = issue_valid_i & ~hazard & ~div_busy_o & ~pipe_stall_i & ~squash_i & ~(issue_div_i & ~SUPPORT_DIVIDE). This is combinational, zero latency.
- hazard_stall_cnt_o increments by 1 each cycle with issue_valid_i & hazard & ~pipe_stall_i & ~squash_i. It saturates at 0xFFFFFFFF and never wraps.
- Squash mid-divide: FSM returns to IDLE, and the late div_complete_i is ignored in IDLE.
- Reset asserted mid-divide returns to IDLE with pending_q = 0.

Test Plan:
- Back-to-back ALU: issue x5 = x1 + x2 (ALU, rd_e1 = 5, result_e1 = 0x11), then consumer of x5 -> accept = 1, operand_ra_o = 0x11, no stall.
- Load-use, SUPPORT_LOAD_BYPASS = 1: lw x6 accepted; next cycle rd_e1 = 6, load_e1 = 1; consumer of x6 -> accept = 0 for 1 cycle, counter = 1. Next cycle rd_e2 = 6, result_e2 = 0xDEAD -> accept = 1, operand = 0xDEAD.
- Same load-use with SUPPORT_LOAD_BYPASS = 0 -> stall 2 cycles; accept when rd_wb = 6; operand = result_wb_i; counter = 2.
- Divide: div x7 accepted -> div_busy_o = 1. Independent instruction held 10 cycles until div_complete_i -> div_busy_o = 0 next cycle; pending[7] cleared when rd_wb = 7.
- Squash during divide plus a pending load: squash_i = 1 -> next cycle div_busy_o = 0, pending_q = 0; a consumer of the squashed rd is accepted with the RF value.
- x0 source with rd_e1 = 0 and pending irrelevant -> operand = 0, accept = 1. Counter preloaded near saturation with forced hazard -> stays at 0xFFFFFFFF.
